// File: rtl/writeback_arb.sv
// Writeback stage arbiter: merges the in-order mem->wb path with round-robin auxiliary
// result channels onto a single registered register-file write port.
module writeback_arb #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REGNO_W    = 6,
  parameter int unsigned NUM_AUX    = 2,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_mem_wb_writeback,
  input  logic [XLEN-1:0]            i_mem_wb_data,
  input  logic [REGNO_W-1:0]         i_mem_wb_rd,
  input  logic                       i_mem_wb_load,
  input  logic [2:0]                 i_mem_wb_funct3,
  input  logic [1:0]                 i_mem_wb_addr_lo,
  input  logic [NUM_AUX-1:0]         i_aux_valid,
  input  logic [NUM_AUX*XLEN-1:0]    i_aux_data,
  input  logic [NUM_AUX*REGNO_W-1:0] i_aux_rd,
  output logic [NUM_AUX-1:0]         o_aux_ready,
  output logic                       o_stall_req,
  output logic                       o_write,
  output logic [XLEN-1:0]            o_data,
  output logic [REGNO_W-1:0]         o_regno
);

  localparam int unsigned PtrW = (NUM_AUX > 1) ? $clog2(NUM_AUX) : 1;
  localparam int unsigned CntW = $clog2(STARVE_LIM + 1);

  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               stall_q, stall_d;
  logic               write_q, write_d;
  logic [XLEN-1:0]    data_q, data_d;
  logic [REGNO_W-1:0] regno_q, regno_d;

  logic [NUM_AUX-1:0] grant;
  logic               found;
  logic               aux_xfer;
  logic               slot_used;
  logic [XLEN-1:0]    aux_data_sel;
  logic [REGNO_W-1:0] aux_rd_sel;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [XLEN-1:0]    ch0_data;

  // Rotating priority search starting at the pointer; channel 0 blocks every grant.
  always_comb begin
    grant        = '0;
    found        = 1'b0;
    aux_data_sel = '0;
    aux_rd_sel   = '0;
    ptr_d        = ptr_q;
    if (!i_mem_wb_writeback) begin
      for (int unsigned i = 0; i < NUM_AUX; i++) begin
        for (int unsigned k = 0; k < NUM_AUX; k++) begin
          if (!found && (k == (32'(ptr_q) + i) % NUM_AUX) && i_aux_valid[k]) begin
            found    = 1'b1;
            grant[k] = 1'b1;
          end
        end
      end
    end
    for (int unsigned k = 0; k < NUM_AUX; k++) begin
      if (grant[k]) begin
        aux_data_sel = i_aux_data[k*XLEN +: XLEN];
        aux_rd_sel   = i_aux_rd[k*REGNO_W +: REGNO_W];
        ptr_d        = PtrW'((k + 1) % NUM_AUX);
      end
    end
  end

  assign o_aux_ready = grant & {NUM_AUX{i_rst_n}};
  assign aux_xfer    = |o_aux_ready;
  assign slot_used   = i_mem_wb_writeback | aux_xfer;

  always_comb begin
    unique case (i_mem_wb_addr_lo)
      2'd0:    ld_byte = i_mem_wb_data[7:0];
      2'd1:    ld_byte = i_mem_wb_data[15:8];
      2'd2:    ld_byte = i_mem_wb_data[23:16];
      default: ld_byte = i_mem_wb_data[31:24];
    endcase
    ld_half  = i_mem_wb_addr_lo[1] ? i_mem_wb_data[31:16] : i_mem_wb_data[15:0];
    ch0_data = i_mem_wb_data;
    if (i_mem_wb_load) begin
      case (i_mem_wb_funct3)
        3'b000:  ch0_data = XLEN'($signed(ld_byte));
        3'b100:  ch0_data = XLEN'(ld_byte);
        3'b001:  ch0_data = XLEN'($signed(ld_half));
        3'b101:  ch0_data = XLEN'(ld_half);
        3'b010:  ch0_data = XLEN'($signed(i_mem_wb_data[31:0]));
        default: ch0_data = i_mem_wb_data;
      endcase
    end
  end

  always_comb begin
    write_d = 1'b0;
    data_d  = data_q;
    regno_d = regno_q;
    if (i_mem_wb_writeback) begin
      write_d = (i_mem_wb_rd != '0);
      data_d  = ch0_data;
      regno_d = i_mem_wb_rd;
    end else if (aux_xfer) begin
      write_d = (aux_rd_sel != '0);
      data_d  = aux_data_sel;
      regno_d = aux_rd_sel;
    end
  end

  // Saturating count of cycles where an aux result waits without being accepted.
  always_comb begin
    cnt_d = cnt_q;
    if (aux_xfer || !(|i_aux_valid)) begin
      cnt_d = '0;
    end else if (cnt_q != CntW'(STARVE_LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
    stall_d = (cnt_q == CntW'(STARVE_LIM)) && !aux_xfer;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      write_q <= 1'b0;
      data_q  <= '0;
      regno_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      write_q <= write_d;
      if (slot_used) begin
        data_q  <= data_d;
        regno_q <= regno_d;
      end
    end
  end

  assign o_stall_req = stall_q;
  assign o_write     = write_q;
  assign o_data      = data_q;
  assign o_regno     = regno_q;

endmodule

// File: tb/tb_writeback_arb.sv
// Directed scoreboard bench for writeback_arb: load formatting, round-robin, x0 drop,
// starvation bubble request and mid-operation reset.
module tb_writeback_arb;
  localparam int unsigned XLEN = 32, REGNO_W = 6, NUM_AUX = 2, STARVE_LIM = 8;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b1;
  logic                       mem_wb_writeback, mem_wb_load;
  logic [XLEN-1:0]            mem_wb_data;
  logic [REGNO_W-1:0]         mem_wb_rd;
  logic [2:0]                 mem_wb_funct3;
  logic [1:0]                 mem_wb_addr_lo;
  logic [NUM_AUX-1:0]         aux_valid;
  logic [NUM_AUX*XLEN-1:0]    aux_data;
  logic [NUM_AUX*REGNO_W-1:0] aux_rd;
  logic [NUM_AUX-1:0]         aux_ready;
  logic                       stall_req, wr;
  logic [XLEN-1:0]            data;
  logic [REGNO_W-1:0]         regno;

  writeback_arb #(
    .XLEN(XLEN), .REGNO_W(REGNO_W), .NUM_AUX(NUM_AUX), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mem_wb_writeback(mem_wb_writeback), .i_mem_wb_data(mem_wb_data),
    .i_mem_wb_rd(mem_wb_rd), .i_mem_wb_load(mem_wb_load),
    .i_mem_wb_funct3(mem_wb_funct3), .i_mem_wb_addr_lo(mem_wb_addr_lo),
    .i_aux_valid(aux_valid), .i_aux_data(aux_data), .i_aux_rd(aux_rd),
    .o_aux_ready(aux_ready), .o_stall_req(stall_req),
    .o_write(wr), .o_data(data), .o_regno(regno)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [5:0]  regno;
    logic [31:0] data;
    logic        stall;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          m_ptr, m_cnt;
  logic [5:0]  m_regno;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] aux_word(input int k, input logic [5:0] rd);
    return 32'hA000_0000 | (32'(k) << 8) | 32'(rd);
  endfunction

  task automatic drive_idle();
    mem_wb_writeback = 0; mem_wb_load = 0; mem_wb_data = '0; mem_wb_rd = '0;
    mem_wb_funct3 = '0; mem_wb_addr_lo = '0; aux_valid = '0; aux_data = '0; aux_rd = '0;
  endtask

  // One clock of stimulus; expected output pushed now, popped after the edge.
  task automatic cycle(input string tag, input logic w0, input logic ld, input logic [2:0] f3,
                       input logic [1:0] lo, input logic [5:0] rd0, input logic [31:0] d0,
                       input logic [31:0] exp0, input logic [1:0] av,
                       input logic [5:0] ra0, input logic [5:0] ra1);
    logic [1:0] e_rdy;
    logic [5:0] ra[2];
    exp_t       e, got;
    int         k;
    ra[0] = ra0; ra[1] = ra1; e_rdy = '0;
    if (!w0) begin
      for (int i = 0; i < 2; i++) begin
        k = (m_ptr + i) % 2;
        if (av[k] && e_rdy == 2'b00) e_rdy[k] = 1'b1;
      end
    end
    e.stall = (m_cnt == STARVE_LIM) && (e_rdy == 2'b00);
    if (e_rdy != 2'b00 || av == 2'b00) m_cnt = 0;
    else if (m_cnt < STARVE_LIM) m_cnt++;
    if (w0) begin
      m_regno = rd0; m_data = exp0; e.wr = (rd0 != 0);
    end else if (e_rdy != 2'b00) begin
      k = e_rdy[1] ? 1 : 0;
      m_regno = ra[k]; m_data = aux_word(k, ra[k]); e.wr = (ra[k] != 0);
      m_ptr = (k + 1) % 2;
    end else begin
      e.wr = 1'b0;
    end
    e.regno = m_regno; e.data = m_data;
    sb.push_back(e);
    mem_wb_writeback = w0; mem_wb_load = ld; mem_wb_funct3 = f3; mem_wb_addr_lo = lo;
    mem_wb_rd = rd0; mem_wb_data = d0; aux_valid = av;
    aux_rd = {ra1, ra0}; aux_data = {aux_word(1, ra1), aux_word(0, ra0)};
    #1;
    chk({tag, "/ready"}, 64'(aux_ready), 64'(e_rdy));
    @(posedge clk); #1;
    got = sb.pop_front();
    chk({tag, "/write"}, 64'(wr), 64'(got.wr));
    chk({tag, "/regno"}, 64'(regno), 64'(got.regno));
    chk({tag, "/data"}, 64'(data), 64'(got.data));
    chk({tag, "/stall"}, 64'(stall_req), 64'(got.stall));
  endtask

  initial begin
    drive_idle();
    m_ptr = 0; m_cnt = 0; m_regno = '0; m_data = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst/write", 64'(wr), 64'd0);
    chk("rst/stall", 64'(stall_req), 64'd0);
    chk("rst/data", 64'(data), 64'd0);
    chk("rst/regno", 64'(regno), 64'd0);
    chk("rst/ready", 64'(aux_ready), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Load formatting on channel 0
    cycle("lb",    1, 1, 3'b000, 2'd1, 6'd5, 32'h1234_80FF, 32'hFFFF_FF80, 2'b00, 0, 0);
    cycle("lbu",   1, 1, 3'b100, 2'd1, 6'd5, 32'h1234_80FF, 32'h0000_0080, 2'b00, 0, 0);
    cycle("lh",    1, 1, 3'b001, 2'd2, 6'd6, 32'h8001_7FFF, 32'hFFFF_8001, 2'b00, 0, 0);
    cycle("lhu",   1, 1, 3'b101, 2'd3, 6'd6, 32'h8001_7FFF, 32'h0000_8001, 2'b00, 0, 0);
    cycle("lh0",   1, 1, 3'b001, 2'd0, 6'd7, 32'h8001_7FFF, 32'h0000_7FFF, 2'b00, 0, 0);
    cycle("lb3",   1, 1, 3'b000, 2'd3, 6'd8, 32'h7F00_0000, 32'h0000_007F, 2'b00, 0, 0);
    cycle("lbu0",  1, 1, 3'b100, 2'd0, 6'd9, 32'h1234_80FF, 32'h0000_00FF, 2'b00, 0, 0);
    cycle("lw",    1, 1, 3'b010, 2'd0, 6'd4, 32'h8001_7FFF, 32'h8001_7FFF, 2'b00, 0, 0);
    cycle("f3_011", 1, 1, 3'b011, 2'd1, 6'd3, 32'hCAFE_F00D, 32'hCAFE_F00D, 2'b00, 0, 0);
    cycle("noload", 1, 0, 3'b000, 2'd1, 6'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 0, 0);
    cycle("ch0_x0", 1, 0, 3'b000, 2'd0, 6'd0, 32'h0000_0055, 32'h0000_0055, 2'b00, 0, 0);
    cycle("idle",   0, 0, 3'b000, 2'd0, 6'd0, 32'h0, 32'h0, 2'b00, 0, 0);
    cycle("ch0_prio", 1, 0, 3'b000, 2'd0, 6'd8, 32'h1111, 32'h1111, 2'b11, 6'd10, 6'd11);

    // Round-robin: aux0, aux1, aux0
    cycle("rr0", 0, 0, 0, 0, 0, 0, 0, 2'b11, 6'd10, 6'd11);
    cycle("rr1", 0, 0, 0, 0, 0, 0, 0, 2'b11, 6'd10, 6'd11);
    cycle("rr2", 0, 0, 0, 0, 0, 0, 0, 2'b11, 6'd10, 6'd11);

    // x0 drop on aux1, then pointer back at aux0
    cycle("x0drop", 0, 0, 0, 0, 0, 0, 0, 2'b10, 6'd0, 6'd0);
    cycle("x0next", 0, 0, 0, 0, 0, 0, 0, 2'b11, 6'd12, 6'd13);

    // Starvation: channel 0 busy every cycle while aux0 waits
    for (int c = 0; c < 10; c++) begin
      cycle("starve", 1, 0, 0, 0, 6'd7, 32'(c), 32'(c), 2'b01, 6'd9, 6'd0);
      if (c == 7) chk("stall_cycle8", 64'(stall_req), 64'd0);
      if (c == 8) chk("stall_cycle9", 64'(stall_req), 64'd1);
    end
    cycle("bubble",  0, 0, 0, 0, 0, 0, 0, 2'b01, 6'd9, 6'd0);
    cycle("unstall", 0, 0, 0, 0, 0, 0, 0, 2'b00, 6'd0, 6'd0);

    // Build up a stall again with the pointer at aux1, then reset mid-operation
    for (int c = 0; c < 10; c++) begin
      cycle("starve2", 1, 0, 0, 0, 6'd7, 32'h100 + 32'(c), 32'h100 + 32'(c), 2'b01, 6'd9, 6'd0);
    end
    chk("pre_rst/stall", 64'(stall_req), 64'd1);
    #2 rst_n = 1'b0;
    mem_wb_writeback = 1'b0;
    #1;
    chk("mid_rst/write", 64'(wr), 64'd0);
    chk("mid_rst/stall", 64'(stall_req), 64'd0);
    chk("mid_rst/ready", 64'(aux_ready), 64'd0);
    chk("mid_rst/data", 64'(data), 64'd0);
    @(posedge clk); #1;
    chk("in_rst/ready", 64'(aux_ready), 64'd0);
    chk("in_rst/write", 64'(wr), 64'd0);
    drive_idle();
    @(negedge clk) rst_n = 1'b1;
    sb.delete();
    m_ptr = 0; m_cnt = 0; m_regno = '0; m_data = '0;
    @(posedge clk); #1;
    cycle("post_rst0", 0, 0, 0, 0, 0, 0, 0, 2'b11, 6'd20, 6'd21);
    cycle("post_rst1", 0, 0, 0, 0, 0, 0, 0, 2'b11, 6'd20, 6'd21);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
